ro_edge_counter: RTL

//  Counts rising edges of the free-running ring-oscillator output over successive

---
 rtl/ro_pkg.sv | 32 +++
 rtl/sync_edge_det.sv | 43 ++++
 rtl/ro_edge_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ro_pkg.sv
// ----------------------------------------------------------------------------
// ro_pkg
//   Shared types and helpers for the ring-oscillator edge counter.
//   - CNT_W_DEF      : default accumulator / result width
//   - ro_cnt_state_t : window state (discarding first partial window, counting)
//   - sat_inc        : add a single edge to an accumulator, clamping at the
//                      all-ones value of a cnt_w-bit counter
// ----------------------------------------------------------------------------
package ro_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic {
      WAIT_FIRST = 1'b0,   // partial window after reset, edges ignored
      COUNT      = 1'b1    // accumulating edges of a full window
   } ro_cnt_state_t;

   // Saturating increment on a counter of cnt_w bits (cnt_w <= 64). Operands
   // travel as 64-bit values so one helper serves every instance width; the
   // caller zero-extends its accumulator and truncates the result back.
   function automatic logic [63:0] sat_inc(input logic [63:0] acc,
                                           input logic        inc,
                                           input int          cnt_w);
      logic [63:0] max_val;
      max_val = (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
      if (inc && (acc != max_val)) begin
         return acc + 64'd1;
      end
      return acc;
   endfunction

endpackage : ro_pkg

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous level into the clk domain through a flop chain and
//   produces a registered one-cycle pulse on each synchronized rising edge.
//   A rise on async_in shows up on edge_pulse SYNC_STAGES+1 clocks later.
//
//   Ports
//     clk        in  system clock
//     rst        in  asynchronous reset, active-high
//     async_in   in  level from another clock domain (ring oscillator)
//     edge_pulse out one-cycle pulse per synchronized rising edge
// ----------------------------------------------------------------------------
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour; blocking here would
   // collapse the synchronizer chain into a single stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q     <= sync_out;
         edge_pulse <= sync_out & ~prev_q;
      end
   end

endmodule : sync_edge_det

// File: rtl/ro_edge_counter.sv
// ----------------------------------------------------------------------------
// ro_edge_counter
//   Counts rising edges of a free-running ring oscillator over measurement
//   windows delimited by the window_done strobe. Each closed window's count is
//   latched into an output register and offered with a valid/ready handshake.
//   The partial window between reset and the first strobe is discarded.
//   A window closing while the previous result is still unaccepted is dropped
//   and flagged with drop_pulse. ro_in must stay below clk/2 after sync.
//
//   Ports
//     clk          in   system clock
//     rst          in   asynchronous reset, active-high
//     ro_in        in   raw ring-oscillator output, asynchronous to clk
//     window_done  in   one-cycle strobe closing the current window
//     cnt_data     out  edge count of the last captured window
//     cnt_sat      out  captured window saturated at 2^CNT_W-1
//     cnt_valid    out  cnt_data/cnt_sat valid; held until accepted
//     cnt_ready    in   consumer accepts when cnt_valid && cnt_ready
//     drop_pulse   out  one cycle: window closed while result unaccepted
// ----------------------------------------------------------------------------
module ro_edge_counter
   import ro_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro_in,
   input  logic             window_done,
   output logic [CNT_W-1:0] cnt_data,
   output logic             cnt_sat,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             drop_pulse
);

   ro_cnt_state_t    state, state_nxt;
   logic [CNT_W-1:0] acc, acc_nxt;
   logic             sat_r, sat_nxt;
   logic [CNT_W-1:0] data_nxt;
   logic             csat_nxt;
   logic             valid_nxt;
   logic             drop_nxt;

   logic             edge_pulse;
   logic [CNT_W-1:0] acc_sum;
   logic             sat_hit;
   logic             can_load;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_det (
      .clk        (clk),
      .rst        (rst),
      .async_in   (ro_in),
      .edge_pulse (edge_pulse)
   );

   // Accumulator including this cycle's edge: an edge arriving together with
   // window_done belongs to the window being closed.
   assign acc_sum  = CNT_W'(sat_inc(64'(acc), edge_pulse, CNT_W));
   assign sat_hit  = edge_pulse && (acc == '1);
   // The output register is free if empty or being drained this very cycle.
   assign can_load = !cnt_valid || cnt_ready;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WAIT_FIRST;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------- next state / datapath
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_nxt = state;
      acc_nxt   = acc;
      sat_nxt   = sat_r;
      data_nxt  = cnt_data;
      csat_nxt  = cnt_sat;
      valid_nxt = cnt_valid && !cnt_ready;
      drop_nxt  = 1'b0;

      case (state)
         WAIT_FIRST: begin
            acc_nxt = '0;
            sat_nxt = 1'b0;
            if (window_done) begin
               state_nxt = COUNT;
            end
         end

         COUNT: begin
            if (window_done) begin
               acc_nxt = '0;
               sat_nxt = 1'b0;
               if (can_load) begin
                  data_nxt  = acc_sum;
                  csat_nxt  = sat_r | sat_hit;
                  valid_nxt = 1'b1;
               end else begin
                  // Held result has priority; the new count is discarded.
                  valid_nxt = 1'b1;
                  drop_nxt  = 1'b1;
               end
            end else begin
               acc_nxt = acc_sum;
               sat_nxt = sat_r | sat_hit;
            end
         end

         default: begin
            state_nxt = WAIT_FIRST;
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
         end
      endcase
   end

   // ------------------------------------------- accumulator and output regs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         sat_r      <= 1'b0;
         cnt_data   <= '0;
         cnt_sat    <= 1'b0;
         cnt_valid  <= 1'b0;
         drop_pulse <= 1'b0;
      end else begin
         acc        <= acc_nxt;
         sat_r      <= sat_nxt;
         cnt_data   <= data_nxt;
         cnt_sat    <= csat_nxt;
         cnt_valid  <= valid_nxt;
         drop_pulse <= drop_nxt;
      end
   end

endmodule : ro_edge_counter
